// File: rtl/pipe_shifter.sv
// pipe_shifter: two-stage pipelined barrel shifter/rotator with valid/ready
// handshaking on both sides.
// Modes: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101..111 PASS.
// Stage 1 applies the low ceil(SW/2) shift levels. Stage 2 applies the
// remaining levels and registers the result and flags.
// Optional feature: define PIPE_SHIFTER_FLAGS_EN to compute carry/zero.
// When it is undefined, carry and zero are tied to 0.
module pipe_shifter #(
    parameter int WIDTH = 24,
    parameter int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] shift,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero
);

    localparam int               LO    = (SW + 1) / 2;   // levels done in stage 1
    localparam int               HI    = SW - LO;        // levels done in stage 2
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] W_ONE = WIDTH'(1);

    typedef enum logic [2:0] {
        OP_SLL  = 3'b000,
        OP_SRL  = 3'b001,
        OP_SRA  = 3'b010,
        OP_ROL  = 3'b011,
        OP_ROR  = 3'b100,
        OP_PASS = 3'b101
    } op_e;

    // One barrel level: move x by s positions according to the operation.
    function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] x,
                                                     input op_e op, input int s);
        logic [WIDTH-1:0] y;
        case (op)
            OP_SLL:  y = x << s;
            OP_SRL:  y = x >> s;
            OP_SRA:  y = $signed(x) >>> s;
            OP_ROL:  y = (x << s) | (x >> (WIDTH - s));
            OP_ROR:  y = (x >> s) | (x << (WIDTH - s));
            default: y = x;
        endcase
        return y;
    endfunction

    logic             ld1, ld2;
    op_e              op_in;
    logic             over;
    logic [WIDTH-1:0] fill;
    logic [SW-1:0]    amt;
    logic [WIDTH-1:0] part;
    logic [WIDTH-1:0] final_res;

    logic             v1_d, v1_q;
    logic [WIDTH-1:0] p1_d, p1_q;
    logic [HI-1:0]    hi1_d, hi1_q;
    op_e              op1_d, op1_q;
    logic             v2_d, v2_q;
    logic [WIDTH-1:0] res_d, res_q;

    // Decode the request: saturate out-of-range shifts, reduce rotates mod WIDTH,
    // then run the low barrel levels.
    // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        op_in = (mode > 3'b100) ? OP_PASS : op_e'(mode);
        over  = (shift >= W_VAL);
        fill  = data;
        amt   = shift[SW-1:0];
        case (op_in)
            OP_SLL, OP_SRL: if (over) begin
                fill = '0;
                amt  = '0;
            end
            OP_SRA: if (over) begin
                fill = {WIDTH{data[WIDTH-1]}};
                amt  = '0;
            end
            OP_ROL, OP_ROR: amt = SW'(shift % W_VAL);
            default:        amt = '0;
        endcase
        part = fill;
        for (int k = 0; k < LO; k++) begin
            if (amt[k]) part = shift_level(part, op_in, 1 << k);
        end
    end

    // Handshake, stage-1 load, the remaining barrel levels and stage-2 load.
    always_comb begin
        ld2      = !v2_q || out_ready;
        ld1      = !v1_q || ld2;
        in_ready = ld1;

        v1_d  = ld1 ? in_valid : v1_q;
        p1_d  = p1_q;
        hi1_d = hi1_q;
        op1_d = op1_q;
        if (ld1 && in_valid) begin
            p1_d  = part;
            hi1_d = amt[SW-1:LO];
            op1_d = op_in;
        end

        final_res = p1_q;
        for (int k = 0; k < HI; k++) begin
            if (hi1_q[k]) final_res = shift_level(final_res, op1_q, 1 << (LO + k));
        end

        v2_d  = ld2 ? v1_q : v2_q;
        res_d = (ld2 && v1_q) ? final_res : res_q;
    end

    // Valid bits and output payload; reset empties the pipe and clears the outputs.
    // NOTE: sequential state is assigned with <= so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            res_q <= '0;
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            res_q <= res_d;
        end
    end

    // Stage-1 payload.
    // NOTE: no reset on this payload; it is only ever consumed while v1_q is set.
    always_ff @(posedge clk) begin
        p1_q  <= p1_d;
        hi1_q <= hi1_d;
        op1_q <= op1_d;
    end

    assign out_valid = v2_q;
    assign result    = res_q;

`ifdef PIPE_SHIFTER_FLAGS_EN
    logic [WIDTH-1:0] tap;
    logic             c_in;
    logic             c1_d, c1_q;
    logic             carry_d, carry_q;
    logic             zero_d, zero_q;

    // Last bit moved out, picked from the operand; carried alongside the partial result.
    always_comb begin
        tap  = '0;
        c_in = 1'b0;
        case (op_in)
            OP_SLL: if (shift != '0 && shift <= W_VAL) begin
                tap  = data >> (W_VAL - shift);
                c_in = tap[0];
            end
            OP_SRL: if (shift != '0 && shift <= W_VAL) begin
                tap  = data >> (shift - W_ONE);
                c_in = tap[0];
            end
            OP_SRA: if (over) begin
                c_in = data[WIDTH-1];
            end else if (shift != '0) begin
                tap  = data >> (shift - W_ONE);
                c_in = tap[0];
            end
            OP_ROL: if (amt != '0) begin
                tap  = data >> (W_VAL - WIDTH'(amt));
                c_in = tap[0];
            end
            OP_ROR: if (amt != '0) begin
                tap  = data >> (WIDTH'(amt) - W_ONE);
                c_in = tap[0];
            end
            default: c_in = 1'b0;
        endcase
        c1_d    = (ld1 && in_valid) ? c_in : c1_q;
        carry_d = (ld2 && v1_q) ? c1_q : carry_q;
        zero_d  = (ld2 && v1_q) ? (final_res == '0) : zero_q;
    end

    // Flag registers: stage-1 carry follows the payload, stage-2 flags reset with result.
    always_ff @(posedge clk) begin
        c1_q <= c1_d;
        if (reset) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    assign carry = carry_q;
    assign zero  = zero_q;
`else
    assign carry = 1'b0;
    assign zero  = 1'b0;
`endif

endmodule
